// File: rtl/ram16_initiator.sv
// Host-side controller for the 4x32 byte-strobed RAM16 macro: steers byte/half/word
// requests onto the strobed port, extracts right-aligned read data, and runs a clear sequence.
module ram16_initiator #(
  parameter logic [31:0] CLR_VALUE = 32'h0000_0000,
  parameter bit          SIGN_EXT  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic        clr_start,
  output logic        clr_done,
  output logic        busy,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [1:0]  ram_a,
  output logic [31:0] ram_di,
  input  logic [31:0] ram_do
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_t;

  state_t     state;
  logic       lat_we;
  logic [1:0] lat_lane;
  logic [1:0] lat_size;

  function automatic logic is_legal(input logic [3:0] addr, input logic [1:0] size);
    logic ok;
    case (size)
      2'd0:    ok = 1'b1;
      2'd1:    ok = ~addr[0];
      2'd2:    ok = (addr[1:0] == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << lane;
      2'd1:    s = 4'b0011 << lane;
      default: s = 4'hF;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] steer(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'd0:    d = {4{wdata[7:0]}};
      2'd1:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] rdo, input logic [1:0] size,
                                          input logic [1:0] lane);
    logic [31:0] sh;
    logic [31:0] d;
    sh = rdo >> {lane, 3'b000};
    case (size)
      2'd0:    d = {{24{SIGN_EXT & sh[7]}}, sh[7:0]};
      2'd1:    d = {{16{SIGN_EXT & sh[15]}}, sh[15:0]};
      default: d = sh;
    endcase
    return d;
  endfunction

  // clr_start must win over a simultaneous request, so ready drops combinationally with it.
  assign req_ready = rst_n & (state == IDLE) & ~clr_start;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      lat_lane   <= 2'd0;
      lat_size   <= 2'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      clr_done   <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 4'h0;
      ram_a      <= 2'd0;
      ram_di     <= 32'h0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state  <= CLEAR;
            ram_en <= 1'b1;
            ram_we <= 4'hF;
            ram_a  <= 2'd0;
            ram_di <= CLR_VALUE;
          end else if (req_valid) begin
            lat_we   <= req_we;
            lat_lane <= req_addr[1:0];
            lat_size <= req_size;
            if (is_legal(req_addr, req_size)) begin
              state  <= ACCESS;
              ram_en <= 1'b1;
              ram_a  <= req_addr[3:2];
              ram_we <= req_we ? strobe(req_size, req_addr[1:0]) : 4'h0;
              ram_di <= req_we ? steer(req_size, req_wdata) : 32'h0;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end
          end
        end
        ACCESS: begin
          state      <= RESP;
          ram_en     <= 1'b0;
          ram_we     <= 4'h0;
          ram_a      <= 2'd0;
          ram_di     <= 32'h0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= lat_we ? 32'h0 : extract(ram_do, lat_size, lat_lane);
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
          end
        end
        CLEAR: begin
          if (ram_a == 2'd3) begin
            state    <= IDLE;
            ram_en   <= 1'b0;
            ram_we   <= 4'h0;
            ram_a    <= 2'd0;
            ram_di   <= 32'h0;
            clr_done <= 1'b1;
          end else begin
            ram_a <= ram_a + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram16_initiator.sv
// Scoreboard bench for ram16_initiator: two instances (zero- and sign-extending, different
// clear words) share stimulus; a byte-array reference model predicts RAM cycles and responses.
module tb_ram16_initiator;

  localparam logic [31:0] CLR0 = 32'h0000_0000;
  localparam logic [31:0] CLR1 = 32'hA5C3_0F96;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, clr_start;
  logic [3:0]  req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic [1:0]  mode;
  logic        rr_rand;
  logic        resp_ready;

  logic        req_ready0, resp_valid0, resp_err0, clr_done0, busy0, ram_en0;
  logic [31:0] resp_rdata0, ram_di0, ram_do0;
  logic [3:0]  ram_we0;
  logic [1:0]  ram_a0;
  logic        req_ready1, resp_valid1, resp_err1, clr_done1, busy1, ram_en1;
  logic [31:0] resp_rdata1, ram_di1, ram_do1;
  logic [3:0]  ram_we1;
  logic [1:0]  ram_a1;

  always #5 clk = ~clk;

  // mode 0: random resp_ready, 1: held low, 2: held high
  assign resp_ready = (mode == 2'd1) ? 1'b0 : (mode == 2'd2) ? 1'b1 : rr_rand;

  initial begin
    rr_rand = 1'b1;
    forever begin
      @(posedge clk);
      #2 rr_rand = 1'($urandom_range(0, 1));
    end
  end

  ram16_initiator #(.CLR_VALUE(CLR0), .SIGN_EXT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .resp_valid(resp_valid0),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .clr_start(clr_start), .clr_done(clr_done0), .busy(busy0), .ram_en(ram_en0),
    .ram_we(ram_we0), .ram_a(ram_a0), .ram_di(ram_di0), .ram_do(ram_do0));

  ram16_initiator #(.CLR_VALUE(CLR1), .SIGN_EXT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .resp_valid(resp_valid1),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .clr_start(clr_start), .clr_done(clr_done1), .busy(busy1), .ram_en(ram_en1),
    .ram_we(ram_we1), .ram_a(ram_a1), .ram_di(ram_di1), .ram_do(ram_do1));

  // RAM16 macro stand-ins
  logic [31:0] mem0 [4];
  logic [31:0] mem1 [4];

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] di,
                                             input logic [3:0] we);
    logic [31:0] m;
    m = old;
    for (int j = 0; j < 4; j++) if (we[j]) m[8*j +: 8] = di[8*j +: 8];
    return m;
  endfunction

  assign ram_do0 = ram_en0 ? mem0[ram_a0] : 32'h0;
  assign ram_do1 = ram_en1 ? mem1[ram_a1] : 32'h0;
  always @(posedge clk) if (ram_en0) mem0[ram_a0] <= mergeBytes(mem0[ram_a0], ram_di0, ram_we0);
  always @(posedge clk) if (ram_en1) mem1[ram_a1] <= mergeBytes(mem1[ram_a1], ram_di1, ram_we1);

  typedef struct {
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        err;
    int          exp_rise;
  } resp_t;

  typedef struct {
    logic [3:0]  we;
    logic [1:0]  a;
    logic [31:0] di0;
    logic [31:0] di1;
    logic        chk_di;
  } ram_t;

  resp_t      resp_q[$];
  ram_t       ram_q[$];
  logic [7:0] ref0 [16];
  logic [7:0] ref1 [16];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic isLegal(input logic [3:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b0;
    return (int'(addr) % (1 << size)) == 0;
  endfunction

  task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [1:0] size,
                               input logic [31:0] wdata);
    bit    accepted = 0;
    int    a, n, lane;
    resp_t r;
    ram_t  t;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (req_ready0) accepted = 1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = 4'($urandom_range(0, 15));
    req_size  = 2'($urandom_range(0, 3));
    req_wdata = $urandom;
    if (!accepted) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      return;
    end
    a = cyc;
    n = 1 << size;
    lane = int'(addr[1:0]);
    r.rdata0 = 32'h0;
    r.rdata1 = 32'h0;
    if (!isLegal(addr, size)) begin
      r.err = 1'b1;
      r.exp_rise = a;
    end else begin
      r.err = 1'b0;
      r.exp_rise = a + 1;
      t.a = addr[3:2]; t.we = 4'h0; t.di0 = 32'h0; t.di1 = 32'h0; t.chk_di = we;
      if (we) begin
        for (int j = 0; j < 4; j++) begin
          t.we[j] = (j >= lane) && (j < lane + n);
          t.di0[8*j +: 8] = wdata[8*(j % n) +: 8];
        end
        t.di1 = t.di0;
        for (int i = 0; i < n; i++) begin
          ref0[int'(addr) + i] = wdata[8*i +: 8];
          ref1[int'(addr) + i] = wdata[8*i +: 8];
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          r.rdata0[8*i +: 8] = ref0[int'(addr) + i];
          r.rdata1[8*i +: 8] = ref1[int'(addr) + i];
        end
        if (n < 4 && r.rdata1[8*n-1]) for (int b = 8*n; b < 32; b++) r.rdata1[b] = 1'b1;
      end
      ram_q.push_back(t);
    end
    resp_q.push_back(r);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (resp_q.size() != 0 || busy0); i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_idle", {31'd0, busy0}, 32'd0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("reset_outputs0", {31'd0, |{req_ready0, resp_valid0, resp_rdata0, resp_err0,
                clr_done0, busy0, ram_en0, ram_we0, ram_a0, ram_di0}}, 32'd0);
    checkOutput("reset_outputs1", {31'd0, |{req_ready1, resp_valid1, resp_rdata1, resp_err1,
                clr_done1, busy1, ram_en1, ram_we1, ram_a1, ram_di1}}, 32'd0);
  endtask

  task automatic startClear(input bit abort);
    ram_t        t;
    logic [31:0] clrv;
    clrv = CLR1;
    clr_start = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h0; req_size = 2'd2; req_wdata = $urandom;
    #1 checkOutput("clr_priority_ready", {31'd0, req_ready0}, 32'd0);
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    req_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      t.we = 4'hF; t.a = 2'(w); t.di0 = CLR0; t.di1 = CLR1; t.chk_di = 1'b1;
      ram_q.push_back(t);
      if (!abort || w < 2)
        for (int j = 0; j < 4; j++) begin
          ref0[4*w + j] = 8'h00;
          ref1[4*w + j] = clrv[8*j +: 8];
        end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (abort && k == 2) begin
        #1 rst_n = 1'b0;
        #1 checkResetOutputs();
        ram_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 checkOutput("ready_after_abort", {31'd0, req_ready0}, 32'd1);
        return;
      end
      checkOutput("clr_done_early", {31'd0, clr_done0}, 32'd0);
      checkOutput("clr_busy", {31'd0, busy0}, 32'd1);
    end
    @(negedge clk);
    checkOutput("clr_done0", {31'd0, clr_done0}, 32'd1);
    checkOutput("clr_done1", {31'd0, clr_done1}, 32'd1);
    checkOutput("clr_idle", {31'd0, busy0}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every completed response and every RAM cycle against the queues.
  logic  prev_valid = 1'b0;
  int    rise_cyc = 0;
  resp_t mr;
  ram_t  mt;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (resp_valid0 && !prev_valid) rise_cyc = cyc;
      prev_valid = resp_valid0;
      if (resp_valid0 && resp_ready) begin
        if (resp_q.size() == 0) checkOutput("unexpected_resp", 32'd1, 32'd0);
        else begin
          mr = resp_q.pop_front();
          checkOutput("resp_rdata0", resp_rdata0, mr.rdata0);
          checkOutput("resp_rdata1", resp_rdata1, mr.rdata1);
          checkOutput("resp_err0", {31'd0, resp_err0}, {31'd0, mr.err});
          checkOutput("resp_err1", {31'd0, resp_err1}, {31'd0, mr.err});
          checkOutput("resp_valid1", {31'd0, resp_valid1}, 32'd1);
          checkOutput("resp_latency", rise_cyc, mr.exp_rise);
        end
      end
      if (ram_en0 || ram_en1) begin
        if (ram_q.size() == 0) checkOutput("unexpected_ram_en", 32'd1, 32'd0);
        else begin
          mt = ram_q.pop_front();
          checkOutput("ram_en0", {31'd0, ram_en0}, 32'd1);
          checkOutput("ram_en1", {31'd0, ram_en1}, 32'd1);
          checkOutput("ram_we0", {28'd0, ram_we0}, {28'd0, mt.we});
          checkOutput("ram_we1", {28'd0, ram_we1}, {28'd0, mt.we});
          checkOutput("ram_a0", {30'd0, ram_a0}, {30'd0, mt.a});
          checkOutput("ram_a1", {30'd0, ram_a1}, {30'd0, mt.a});
          if (mt.chk_di) begin
            checkOutput("ram_di0", ram_di0, mt.di0);
            checkOutput("ram_di1", ram_di1, mt.di1);
          end
        end
      end
    end
  end

  initial begin
    mode = 2'd2;
    rst_n = 1'b0;
    clr_start = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 4'h0; req_size = 2'd0; req_wdata = 32'h0;
    #1 checkResetOutputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 checkOutput("ready_after_reset", {31'd0, req_ready0}, 32'd1);

    $display("[TB] clear and read back");
    startClear(1'b0);
    for (int w = 0; w < 4; w++) applyStimulus(1'b0, 4'(4*w), 2'd2, 32'h0);
    drain();

    $display("[TB] directed steering and extraction");
    applyStimulus(1'b1, 4'd4, 2'd2, 32'hDEADBEEF);
    applyStimulus(1'b0, 4'd6, 2'd0, 32'h0);
    applyStimulus(1'b1, 4'd8, 2'd2, 32'hAABBCCDD);
    applyStimulus(1'b1, 4'd10, 2'd1, 32'h0000_1234);
    applyStimulus(1'b0, 4'd8, 2'd2, 32'h0);
    applyStimulus(1'b0, 4'd7, 2'd0, 32'h0);
    applyStimulus(1'b0, 4'd6, 2'd1, 32'h0);
    applyStimulus(1'b0, 4'd5, 2'd1, 32'h0);
    applyStimulus(1'b0, 4'd2, 2'd2, 32'h0);
    applyStimulus(1'b0, 4'd0, 2'd3, 32'h0);
    applyStimulus(1'b1, 4'd3, 2'd1, 32'hFFFF_FFFF);
    drain();

    $display("[TB] response stall");
    mode = 2'd1;
    applyStimulus(1'b0, 4'd4, 2'd2, 32'h0);
    for (int i = 0; i < 20 && !resp_valid0; i++) @(negedge clk);
    checkOutput("stall_valid_seen", {31'd0, resp_valid0}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_valid", {31'd0, resp_valid0}, 32'd1);
      checkOutput("stall_rdata", resp_rdata0, resp_q[0].rdata0);
      checkOutput("stall_ready", {31'd0, req_ready0}, 32'd0);
    end
    @(posedge clk);
    #1 mode = 2'd2;
    @(posedge clk);
    @(negedge clk);
    checkOutput("release_idle", {31'd0, busy0}, 32'd0);
    checkOutput("release_ready", {31'd0, req_ready0}, 32'd1);
    @(posedge clk);
    #1 applyStimulus(1'b0, 4'd10, 2'd1, 32'h0);
    drain();

    $display("[TB] randomized traffic");
    mode = 2'd0;
    repeat (80) applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                              2'($urandom_range(0, 3)), $urandom);
    drain();
    mode = 2'd2;

    $display("[TB] reset during clear");
    for (int w = 0; w < 4; w++) applyStimulus(1'b1, 4'(4*w), 2'd2, $urandom);
    drain();
    startClear(1'b1);
    for (int w = 0; w < 4; w++) applyStimulus(1'b0, 4'(4*w), 2'd2, 32'h0);
    applyStimulus(1'b0, 4'd9, 2'd0, 32'h0);
    applyStimulus(1'b0, 4'd14, 2'd1, 32'h0);
    drain();

    checkOutput("resp_q_empty", resp_q.size(), 32'd0);
    checkOutput("ram_q_empty", ram_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram16_initiator.md
Name: ram16_initiator

Overview:
Initiator-side controller that owns the 4x32 byte-strobed RAM16 macro port (EN, 4-bit WE, 2-bit word address, 32-bit write data, combinational read data).
Converts byte-addressed byte/half/word requests on a valid/ready host interface into RAM16 cycles.
Handles lane steering, alignment checking and read-data extraction, and provides a hardware clear sequence.
Sits between the core's load/store path and the RAM16 instance.

Parameters:
CLR_VALUE, 32'h0000_0000, word written to all four locations by the clear sequence
SIGN_EXT, 0, 1 = sign-extend byte/half reads; 0 = zero-extend

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  host request valid
req_ready  output  1  host request accepted when valid&ready
req_we  input  1  1 = write, 0 = read
req_addr  input  4  byte address (word = [3:2], lane = [1:0])
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_wdata  input  32  LSB-aligned write data
resp_valid  output  1  response valid, held until resp_ready
resp_ready  input  1  host accepts response
resp_rdata  output  32  read data, right-aligned; 0 for writes and errors
resp_err  output  1  misaligned or illegal-size request
clr_start  input  1  start clear sequence (sampled in IDLE only)
clr_done  output  1  one-cycle pulse at end of clear
busy  output  1  state != IDLE
ram_en  output  1  to RAM16 EN0
ram_we  output  4  to RAM16 WE0
ram_a  output  2  to RAM16 A0
ram_di  output  32  to RAM16 Di0
ram_do  input  32  from RAM16 Do0 (combinational, gated by EN)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; request, response and clear registers cleared.
  - All outputs 0 except req_ready=1 once rst_n=1.
  - RAM contents are not touched.
  - Reset mid-ACCESS/CLEAR/RESP aborts immediately; a pending response is dropped.
- FSM states: IDLE, ACCESS, RESP, CLEAR.
  - IDLE: req_ready=1.
    - clr_start=1 -> CLEAR. clr_start has priority over req_valid; req_ready=0 that cycle.
    - Else req_valid=1: latch we/addr/size/wdata.
      - Legal request -> ACCESS.
      - Illegal -> RESP with err=1.
  - ACCESS (exactly 1 cycle): ram_en=1, ram_a=addr[3:2].
    - Write: ram_we=strobe, ram_di=replicated data; RAM updates at the closing edge.
    - Read: ram_we=0; ram_do is captured at the closing edge.
    - -> RESP.
  - RESP: resp_valid=1 with stable rdata/err; req_ready=0. Leaves to IDLE on the cycle resp_valid&resp_ready.
  - CLEAR: 4 cycles, ram_a=0,1,2,3 in order, ram_en=1, ram_we=4'hF, ram_di=CLR_VALUE.
    - clr_done=1 in the cycle after the last write, coinciding with the return to IDLE.
- Outside ACCESS/CLEAR: ram_en=0, ram_we=0, ram_a=0, ram_di=0.
- Alignment:
  - Half requires addr[0]=0; word requires addr[1:0]=0; size=3 is always illegal.
  - Illegal requests never assert ram_en.
- Write steering (lane = addr[1:0]):
  - byte: strobe=4'b0001<<lane, di={4{wdata[7:0]}}
  - half: strobe=4'b0011<<lane, di={2{wdata[15:0]}}
  - word: strobe=4'hF, di=wdata
- Read extraction: data=ram_do>>(8*lane).
  - byte: keep [7:0]; half: keep [15:0]; word: all 32 bits.
  - Upper bits are zero, or the sign bit when SIGN_EXT=1.
- Latency: request accepted at edge N -> ACCESS in cycle N+1 -> resp_valid from cycle N+2. Back-to-back throughput is 1 request per 3 cycles with resp_ready tied high.
- Errors: resp_valid from cycle N+1, resp_err=1, rdata=0.
- req_valid/req_wdata changes while not ready are ignored; only the values at the accept edge are used.

Test Plan:
1. Reset, then clr_start pulse -> ram_we=F for 4 cycles with ram_a 0..3, then clr_done pulse; read each word -> rdata=0, err=0.
2. Word write addr=4 data=32'hDEADBEEF, then read byte addr=6 -> rdata=32'h000000AD; with SIGN_EXT=1 -> 32'hFFFFFFAD.
3. Half write addr=10 data=16'h1234 over word 2=32'hAABBCCDD -> ram_we=4'b1100, ram_di=32'h12341234; word read addr=8 -> 32'h1234CCDD.
4. Half read addr=5, word read addr=2, size=3 -> resp_err=1, rdata=0, ram_en never asserted.
5. Hold resp_ready=0 for 5 cycles after a read -> resp_valid and rdata stable, req_ready=0; release -> IDLE next cycle, next request accepted.
6. Assert rst_n=0 during the CLEAR cycle with ram_a=2 -> all outputs 0 asynchronously; after release, words 0-1 = CLR_VALUE, words 2-3 keep their previous contents.
